// File: rtl/flow_ctrl_pkg.sv
// Shared flow codes, FSM state encoding and flow-vector helpers for the rooth pipeline controller.
package flow_ctrl_pkg;

   localparam int FLOW_WIDTH     = 2;
   localparam int REG_ADDR_WIDTH = 5;

   localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'd0;
   localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'd1;
   localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'd2;

   typedef enum logic [1:0] {
      FC_RUN      = 2'd0,
      FC_MEM_WAIT = 2'd1,
      FC_DRAIN    = 2'd2
   } fc_state_e;

   typedef struct packed {
      logic [FLOW_WIDTH-1:0] f_if;
      logic [FLOW_WIDTH-1:0] f_id;
      logic [FLOW_WIDTH-1:0] f_ex;
      logic [FLOW_WIDTH-1:0] f_as;
      logic [FLOW_WIDTH-1:0] f_wb;
   } flow_vec_t;

   function automatic flow_vec_t flows5(input logic [FLOW_WIDTH-1:0] fi, fd, fe, fa, fw);
      flow_vec_t f;
      f.f_if = fi;
      f.f_id = fd;
      f.f_ex = fe;
      f.f_as = fa;
      f.f_wb = fw;
      return f;
   endfunction

   // Hazard resolution outside of any memory stall: interrupt beats jump beats load-use.
   function automatic flow_vec_t run_flows(input logic int_req, input logic jump, input logic lduse);
      flow_vec_t f;
      if (int_req)
         f = flows5(FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK, FLOW_WORK);
      else if (jump)
         f = flows5(FLOW_WORK, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK, FLOW_WORK);
      else if (lduse)
         f = flows5(FLOW_STOP, FLOW_STOP, FLOW_REFRESH, FLOW_WORK, FLOW_WORK);
      else
         f = flows5(FLOW_WORK, FLOW_WORK, FLOW_WORK, FLOW_WORK, FLOW_WORK);
      return f;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID source operands and an in-flight EX load.
module hazard_detect
   import flow_ctrl_pkg::*;
(
   input  logic [REG_ADDR_WIDTH-1:0] rs1,
   input  logic                      rs1_en,
   input  logic [REG_ADDR_WIDTH-1:0] rs2,
   input  logic                      rs2_en,
   input  logic                      ex_load,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
   output logic                      lduse
);

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign lduse = ex_load & (ex_rd != '0) &
                  ((rs1_en & (rs1 == ex_rd)) | (rs2_en & (rs2 == ex_rd)));

endmodule

// File: rtl/flow_ctrl.sv
// Pipeline flow controller: per-stage WORK/STOP/REFRESH codes, memory wait with timeout,
// interrupt drain sequencing and a saturating stall counter.
module flow_ctrl
   import flow_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT  = 16,
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
   input  logic                      id_rs1_en_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
   input  logic                      id_rs2_en_i,
   input  logic                      ex_load_i,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
   input  logic                      jump_i,
   input  logic                      as_mem_req_i,
   input  logic                      mem_ready_i,
   input  logic                      int_req_i,
   input  logic                      stall_cnt_clr_i,
   output logic [FLOW_WIDTH-1:0]     flow_if_o,
   output logic [FLOW_WIDTH-1:0]     flow_id_o,
   output logic [FLOW_WIDTH-1:0]     flow_ex_o,
   output logic [FLOW_WIDTH-1:0]     flow_as_o,
   output logic [FLOW_WIDTH-1:0]     flow_wb_o,
   output logic                      int_ack_o,
   output logic                      bus_err_o,
   output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(MEM_TIMEOUT);
   localparam logic [DW-1:0] DRN_LAST = DW'(DRAIN_CYCLES - 1);

   fc_state_e       state, state_nx;
   logic [TW-1:0]   tmo_cnt, tmo_nx;
   logic [DW-1:0]   drn_cnt, drn_nx;
   logic            ack_nx, err_nx;
   logic            lduse, memstall;
   flow_vec_t       fl;

   hazard_detect u_hazard (
      .rs1     (id_rs1_i),
      .rs1_en  (id_rs1_en_i),
      .rs2     (id_rs2_i),
      .rs2_en  (id_rs2_en_i),
      .ex_load (ex_load_i),
      .ex_rd   (ex_rd_i),
      .lduse   (lduse)
   );

   assign memstall = as_mem_req_i & ~mem_ready_i;

   always_comb begin
      fl       = flows5(FLOW_WORK, FLOW_WORK, FLOW_WORK, FLOW_WORK, FLOW_WORK);
      state_nx = state;
      tmo_nx   = tmo_cnt;
      drn_nx   = drn_cnt;
      ack_nx   = 1'b0;
      err_nx   = 1'b0;
      case (state)
         FC_RUN: begin
            if (memstall) begin
               fl       = flows5(FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_REFRESH);
               tmo_nx   = TW'(1);
               state_nx = FC_MEM_WAIT;
            end else begin
               fl = run_flows(int_req_i, jump_i, lduse);
               if (int_req_i) begin
                  drn_nx   = '0;
                  state_nx = FC_DRAIN;
               end
            end
         end
         FC_MEM_WAIT: begin
            // On release the held hazards are resolved immediately; a still-pending
            // interrupt level is taken from RUN on the following cycle.
            if (mem_ready_i) begin
               fl       = run_flows(int_req_i, jump_i, lduse);
               state_nx = FC_RUN;
            end else if (tmo_cnt == TMO_MAX) begin
               fl       = flows5(FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_REFRESH, FLOW_REFRESH);
               err_nx   = 1'b1;
               state_nx = FC_RUN;
            end else begin
               fl     = flows5(FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_REFRESH);
               tmo_nx = tmo_cnt + TW'(1);
            end
         end
         FC_DRAIN: begin
            if (memstall) begin
               fl = flows5(FLOW_STOP, FLOW_REFRESH, FLOW_REFRESH, FLOW_STOP, FLOW_REFRESH);
            end else begin
               fl = flows5(FLOW_STOP, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK, FLOW_WORK);
               if (drn_cnt == DRN_LAST) begin
                  ack_nx   = 1'b1;
                  state_nx = FC_RUN;
               end else begin
                  drn_nx = drn_cnt + DW'(1);
               end
            end
         end
         default: state_nx = FC_RUN;
      endcase
      if (rst)
         fl = flows5(FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FC_RUN;
         tmo_cnt     <= '0;
         drn_cnt     <= '0;
         int_ack_o   <= 1'b0;
         bus_err_o   <= 1'b0;
         stall_cnt_o <= '0;
      end else begin
         state     <= state_nx;
         tmo_cnt   <= tmo_nx;
         drn_cnt   <= drn_nx;
         int_ack_o <= ack_nx;
         bus_err_o <= err_nx;
         if (stall_cnt_clr_i)
            stall_cnt_o <= '0;
         else if (fl.f_if == FLOW_STOP && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
      end
   end

   assign flow_if_o = fl.f_if;
   assign flow_id_o = fl.f_id;
   assign flow_ex_o = fl.f_ex;
   assign flow_as_o = fl.f_as;
   assign flow_wb_o = fl.f_wb;

endmodule

// File: tb/tb_flow_ctrl.sv
// Bench for flow_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model.
module tb_flow_ctrl;
   import flow_ctrl_pkg::*;

   localparam int MT   = 4;
   localparam int DC   = 2;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int W = 0, S = 1, R = 2;

   typedef int fl5_t[5];

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [REG_ADDR_WIDTH-1:0] rs1, rs2, ex_rd;
   logic rs1_en, rs2_en, ex_load, jump, as_mem_req, mem_ready, int_req, clr;
   logic [FLOW_WIDTH-1:0] f_if, f_id, f_ex, f_as, f_wb;
   logic int_ack, bus_err;
   logic [CW-1:0] stall_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   flow_ctrl #(.MEM_TIMEOUT(MT), .DRAIN_CYCLES(DC), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_i(rs1), .id_rs1_en_i(rs1_en), .id_rs2_i(rs2), .id_rs2_en_i(rs2_en),
      .ex_load_i(ex_load), .ex_rd_i(ex_rd), .jump_i(jump),
      .as_mem_req_i(as_mem_req), .mem_ready_i(mem_ready), .int_req_i(int_req),
      .stall_cnt_clr_i(clr),
      .flow_if_o(f_if), .flow_id_o(f_id), .flow_ex_o(f_ex), .flow_as_o(f_as), .flow_wb_o(f_wb),
      .int_ack_o(int_ack), .bus_err_o(bus_err), .stall_cnt_o(stall_cnt)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic fl5_t mk(input int a, b, c, d, e);
      fl5_t f;
      f[0] = a; f[1] = b; f[2] = c; f[3] = d; f[4] = e;
      return f;
   endfunction

   function automatic fl5_t run_exp(input bit intr, input bit jmp, input bit lu);
      if (intr)     return mk(R, R, R, W, W);
      else if (jmp) return mk(W, R, R, W, W);
      else if (lu)  return mk(S, S, R, W, W);
      else          return mk(W, W, W, W, W);
   endfunction

   // ---------------- behavioural model, compared on every negedge ----------------
   int  m_mode  = 0;   // 0 running, 1 waiting on memory, 2 draining for a trap
   int  m_age   = 0;   // stall cycles spent on the current access
   int  m_drn   = 0;   // drain cycles completed
   int  m_ack   = 0;
   int  m_err   = 0;
   int  m_cnt   = 0;
   bit  m_known = 1'b0;

   always @(negedge clk) begin
      fl5_t e;
      bit ms, lu;
      int nack, nerr;
      ms = as_mem_req && !mem_ready;
      lu = ex_load && (ex_rd != 0) &&
           ((rs1_en && rs1 == ex_rd) || (rs2_en && rs2 == ex_rd));
      if (rst) e = mk(R, R, R, R, R);
      else if (m_mode == 0) e = ms ? mk(S, S, S, S, R) : run_exp(int_req, jump, lu);
      else if (m_mode == 1) begin
         if (mem_ready)        e = run_exp(int_req, jump, lu);
         else if (m_age == MT) e = mk(S, S, S, R, R);
         else                  e = mk(S, S, S, S, R);
      end else e = ms ? mk(S, R, R, S, R) : mk(S, R, R, W, W);

      check("model_if", int'(f_if), e[0]);
      check("model_id", int'(f_id), e[1]);
      check("model_ex", int'(f_ex), e[2]);
      check("model_as", int'(f_as), e[3]);
      check("model_wb", int'(f_wb), e[4]);
      if (m_known) begin
         check("model_int_ack", int'(int_ack), m_ack);
         check("model_bus_err", int'(bus_err), m_err);
         check("model_stall_cnt", int'(stall_cnt), m_cnt);
      end

      nack = 0;
      nerr = 0;
      if (rst) begin
         m_mode = 0; m_age = 0; m_drn = 0; m_cnt = 0; m_known = 1'b1;
      end else begin
         if (clr) m_cnt = 0;
         else if (e[0] == S && m_cnt < CMAX) m_cnt++;
         if (m_mode == 0) begin
            if (ms) begin m_mode = 1; m_age = 1; end
            else if (int_req) begin m_mode = 2; m_drn = 0; end
         end else if (m_mode == 1) begin
            if (mem_ready) m_mode = 0;
            else if (m_age == MT) begin m_mode = 0; nerr = 1; end
            else m_age++;
         end else if (!ms) begin
            if (m_drn == DC - 1) begin m_mode = 0; nack = 1; end
            else m_drn++;
         end
      end
      m_ack = nack;
      m_err = nerr;
   end

   // ---------------- directed helpers ----------------
   task automatic idle();
      rst = 0; rs1 = 0; rs2 = 0; ex_rd = 0; rs1_en = 0; rs2_en = 0; ex_load = 0;
      jump = 0; as_mem_req = 0; mem_ready = 0; int_req = 0; clr = 0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic expf(input string name, input int a, b, c, d, e);
      @(negedge clk);
      check({name, "_if"}, int'(f_if), a);
      check({name, "_id"}, int'(f_id), b);
      check({name, "_ex"}, int'(f_ex), c);
      check({name, "_as"}, int'(f_as), d);
      check({name, "_wb"}, int'(f_wb), e);
   endtask

   initial begin
      idle();
      rst = 1;
      expf("reset", R, R, R, R, R);
      nxt(); idle();
      expf("post_reset", W, W, W, W, W);
      check("post_reset_cnt", int'(stall_cnt), 0);
      check("post_reset_ack", int'(int_ack), 0);
      check("post_reset_err", int'(bus_err), 0);

      // load-use
      nxt(); ex_load = 1; ex_rd = 5; rs1 = 5; rs1_en = 1;
      expf("lduse", S, S, R, W, W);
      nxt(); ex_rd = 0; rs1 = 0;
      expf("lduse_x0", W, W, W, W, W);
      nxt(); idle(); clr = 1;
      expf("clr_cycle", W, W, W, W, W);
      nxt(); clr = 0;
      expf("after_clr", W, W, W, W, W);
      check("after_clr_cnt", int'(stall_cnt), 0);

      // memory wait of three cycles
      nxt(); as_mem_req = 1;
      for (int i = 0; i < 3; i++) begin
         expf("memwait", S, S, S, S, R);
         nxt();
      end
      mem_ready = 1;
      expf("mem_done", W, W, W, W, W);
      check("memwait_cnt", int'(stall_cnt), 3);

      // timeout abort
      nxt(); idle();
      expf("pre_tmo", W, W, W, W, W);
      nxt(); as_mem_req = 1;
      for (int i = 0; i < MT; i++) begin
         expf("tmo_wait", S, S, S, S, R);
         nxt();
      end
      expf("tmo_abort", S, S, S, R, R);
      check("tmo_abort_err", int'(bus_err), 0);
      nxt(); idle();
      expf("tmo_after", W, W, W, W, W);
      check("tmo_err_pulse", int'(bus_err), 1);
      nxt();
      expf("tmo_after2", W, W, W, W, W);
      check("tmo_err_clear", int'(bus_err), 0);

      // interrupt with coincident jump
      nxt(); int_req = 1; jump = 1;
      expf("int_jump", R, R, R, W, W);
      nxt(); idle();
      expf("drain0", S, R, R, W, W);
      check("drain0_ack", int'(int_ack), 0);
      nxt();
      expf("drain1", S, R, R, W, W);
      check("drain1_ack", int'(int_ack), 0);
      nxt();
      expf("drain_done", W, W, W, W, W);
      check("int_ack_pulse", int'(int_ack), 1);
      nxt();
      expf("drain_after", W, W, W, W, W);
      check("int_ack_clear", int'(int_ack), 0);

      // memstall inside drain delays the ack by its length
      nxt(); int_req = 1;
      expf("int2", R, R, R, W, W);
      nxt(); idle(); as_mem_req = 1;
      expf("drain_ms0", S, R, R, S, R);
      nxt();
      expf("drain_ms1", S, R, R, S, R);
      nxt(); mem_ready = 1;
      expf("drain_rdy", S, R, R, W, W);
      nxt(); idle();
      expf("drain_last", S, R, R, W, W);
      check("drain_ms_ack_early", int'(int_ack), 0);
      nxt();
      expf("drain_ms_done", W, W, W, W, W);
      check("drain_ms_ack", int'(int_ack), 1);

      // reset while waiting on memory
      nxt(); idle(); as_mem_req = 1;
      expf("rst_ms0", S, S, S, S, R);
      nxt();
      expf("rst_ms1", S, S, S, S, R);
      nxt(); rst = 1;
      expf("rst_in_wait", R, R, R, R, R);
      nxt(); idle();
      expf("rst_release", W, W, W, W, W);
      check("rst_release_err", int'(bus_err), 0);
      check("rst_release_cnt", int'(stall_cnt), 0);
      nxt();
      expf("rst_release2", W, W, W, W, W);
      check("rst_release2_err", int'(bus_err), 0);

      // stall counter saturation and clear priority
      nxt(); as_mem_req = 1;
      repeat (20) nxt();
      idle();
      expf("sat_idle", W, W, W, W, W);
      check("sat_cnt", int'(stall_cnt), 15);
      nxt();
      expf("sat_hold", W, W, W, W, W);
      check("sat_hold_cnt", int'(stall_cnt), 15);
      nxt(); as_mem_req = 1; clr = 1;
      @(negedge clk);
      nxt(); idle();
      @(negedge clk);
      check("clr_wins_cnt", int'(stall_cnt), 0);

      // randomized traffic, checked by the model
      for (int c = 0; c < 3000; c++) begin
         nxt();
         rst        = ($urandom_range(0, 63) == 0);
         rs1        = REG_ADDR_WIDTH'($urandom_range(0, 3));
         rs2        = REG_ADDR_WIDTH'($urandom_range(0, 3));
         ex_rd      = REG_ADDR_WIDTH'($urandom_range(0, 3));
         rs1_en     = $urandom_range(0, 1) == 1;
         rs2_en     = $urandom_range(0, 1) == 1;
         ex_load    = $urandom_range(0, 1) == 1;
         jump       = $urandom_range(0, 3) == 0;
         as_mem_req = $urandom_range(0, 2) == 0;
         mem_ready  = $urandom_range(0, 2) == 0;
         int_req    = $urandom_range(0, 7) == 0;
         clr        = $urandom_range(0, 15) == 0;
      end
      nxt(); idle();
      @(negedge clk);
      nxt();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
